alu_multicycle: RTL and testbench

Parametrised, registered successor to the processor's 16-bit combinational ALU. It adds a start/busy/done handshake, registered Z/N/C flags and an iterative shift-add multiplier that takes WIDTH cycles. All other operations complete in one cycle. It sits between the register file/accumulator datapath and the control unit. The control unit issues `start` and must wait for `done` before reading `out` or the flags.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_iter.sv | 52 +++++
 rtl/alu_multicycle.sv | 109 ++++++++++
 tb/tb_alu_multicycle.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multicycle ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_PASA = 3'b011;
   localparam logic [2:0] OP_PASB = 3'b100;
   localparam logic [2:0] OP_AND  = 3'b101;
   localparam logic [2:0] OP_OR   = 3'b110;
   localparam logic [2:0] OP_XOR  = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage : alu_pkg

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath: one partial-product step per cycle.
// product presents the accumulator value as it will be after the current
// step, so the controller can capture the full result on the final step edge.
module alu_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic               step,
   output logic [2*WIDTH-1:0] product,
   output logic               last
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      count;

   // Accumulator after this step: add the shifted multiplicand when the
   // current multiplier bit is set.
   always_comb begin
      product = mplier[0] ? (acc + mcand) : acc;
   end

   assign last = (count == CW'(1));

   // Operand latch on load, then one shift-add iteration per step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, A};
         mplier <= B;
         acc    <= '0;
         count  <= CW'(WIDTH);
      end else if (step) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CW'(1);
      end
   end

endmodule : alu_mul_iter

// File: rtl/alu_multicycle.sv
// Registered ALU with start/busy/done handshake, registered Z/N/C flags and a
// WIDTH-cycle shift-add multiplier. All non-multiply opcodes finish in one cycle.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OPW-1:0]   select,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             z_flag,
   output logic             n_flag,
   output logic             c_flag
);

   state_t             state;
   logic [WIDTH:0]     res_wide;
   logic               op_carry;
   logic [2*WIDTH-1:0] product;
   logic               mul_last;
   logic               mul_load;
   logic               mul_step;
   logic [WIDTH-1:0]   mul_low;
   logic               mul_ovf;

   // Single-cycle operation mux; bit WIDTH carries add carry-out or sub borrow.
   always_comb begin
      res_wide = '0;
      case (select)
         OP_ADD:  res_wide = {1'b0, A} + {1'b0, B};
         OP_SUB:  res_wide = {1'b0, B} - {1'b0, A};
         OP_PASA: res_wide = {1'b0, A};
         OP_PASB: res_wide = {1'b0, B};
         OP_AND:  res_wide = {1'b0, A & B};
         OP_OR:   res_wide = {1'b0, A | B};
         OP_XOR:  res_wide = {1'b0, A ^ B};
         default: res_wide = '0;
      endcase
      op_carry = ((select == OP_ADD) || (select == OP_SUB)) ? res_wide[WIDTH] : 1'b0;
   end

   assign mul_load = (state == ST_IDLE) && start && (select == OP_MUL);
   assign mul_step = (state == ST_MUL);
   assign mul_low  = product[WIDTH-1:0];
   assign mul_ovf  = |product[2*WIDTH-1:WIDTH];

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .load    (mul_load),
      .A       (A),
      .B       (B),
      .step    (mul_step),
      .product (product),
      .last    (mul_last)
   );

   // Control FSM with registered result, flags, busy and done pulse.
   // Starts arriving while a multiply runs are simply not looked at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         out    <= '0;
         z_flag <= 1'b0;
         n_flag <= 1'b0;
         c_flag <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (select == OP_MUL) begin
                     busy  <= 1'b1;
                     state <= ST_MUL;
                  end else begin
                     out    <= res_wide[WIDTH-1:0];
                     z_flag <= (res_wide[WIDTH-1:0] == '0);
                     n_flag <= res_wide[WIDTH-1];
                     c_flag <= op_carry;
                     done   <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (mul_last) begin
                  out    <= mul_low;
                  z_flag <= (mul_low == '0);
                  n_flag <= mul_low[WIDTH-1];
                  c_flag <= mul_ovf;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule : alu_multicycle

// File: tb/tb_alu_multicycle.sv
// Randomised self-checking bench for alu_multicycle (WIDTH=16) against a
// plain-arithmetic reference model.
module tb_alu_multicycle;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [2:0]    select = '0;
   logic          busy, done, z_flag, n_flag, c_flag;
   logic [W-1:0]  out;

   int n_vec = 0;
   int n_err = 0;

   alu_multicycle #(.WIDTH(W), .OPW(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .A      (A),
      .B      (B),
      .select (select),
      .busy   (busy),
      .done   (done),
      .out    (out),
      .z_flag (z_flag),
      .n_flag (n_flag),
      .c_flag (c_flag)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: result and carry straight from the opcode table.
   function automatic void model(input int unsigned a, input int unsigned b, input int sel,
                                 output int unsigned r, output bit c);
      longint unsigned p;
      r = 0;
      c = 1'b0;
      case (sel)
         0: begin r = (a + b) % 65536; c = (a + b) > 65535; end
         1: begin r = (b + 65536 - a) % 65536; c = a > b; end
         2: begin p = longint'(a) * longint'(b); r = int'(p % 65536); c = p > 65535; end
         3: r = a;
         4: r = b;
         5: r = a & b;
         6: r = a | b;
         default: r = a ^ b;
      endcase
   endfunction

   // Issue one operation and check the outcome; inject>0 asserts an add
   // start at that cycle of a multiply, which must be ignored.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] sel, input int inject);
      int unsigned er;
      bit          ec;
      int          cyc;
      model(a, b, sel, er, ec);
      @(negedge clk);
      A = a; B = b; select = sel; start = 1'b1;
      @(posedge clk); #1;
      if (sel != 3'd2) begin
         check_val("done_single", done, 1);
         check_val("busy_single", busy, 0);
      end else begin
         check_val("busy_mul_start", busy, 1);
         check_val("done_mul_start", done, 0);
         cyc = 0;
         while (!done && cyc < 40) begin
            @(negedge clk);
            if (cyc + 1 == inject) begin
               start = 1'b1; select = 3'd0; A = $urandom; B = $urandom;
            end else begin
               start = 1'b0; A = $urandom; B = $urandom; select = 3'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
            if (!done && cyc < 16) check_val("busy_mid", busy, 1);
         end
         check_val("mul_latency", cyc, 16);
         check_val("busy_at_done", busy, 0);
      end
      check_val($sformatf("out op%0d a%0h b%0h", sel, a, b), out, er);
      check_val("z_flag", z_flag, (er == 0));
      check_val("n_flag", n_flag, er[15]);
      check_val("c_flag", c_flag, ec);
      @(negedge clk);
      start = 1'b0; A = $urandom; B = $urandom; select = 3'($urandom);
      @(posedge clk); #1;
      check_val("done_one_cycle", done, 0);
      check_val("out_hold", out, er);
   endtask

   initial begin
      #2;
      check_val("rst_out", out, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_flags", {z_flag, n_flag, c_flag}, 0);
      @(negedge clk); rst = 1'b0;

      run_op(16'd60, 16'd62, 3'd0, 0);
      run_op(16'd40, 16'd40, 3'd1, 0);
      run_op(16'd50, 16'd20, 3'd1, 0);
      run_op(16'd40, 16'd40, 3'd2, 0);
      run_op(16'd300, 16'd300, 3'd2, 0);
      run_op(16'd40, 16'd40, 3'd2, 5);
      run_op(16'hFFFF, 16'd1, 3'd0, 0);
      run_op(16'h8000, 16'd7, 3'd3, 0);
      run_op(16'hFFFF, 16'hFFFF, 3'd2, 0);
      run_op(16'd0, 16'hABCD, 3'd2, 0);

      for (int i = 0; i < 40; i++)
         run_op(16'($urandom), 16'($urandom), 3'($urandom), 0);

      // Reset in the middle of a multiply.
      @(negedge clk);
      A = 16'd123; B = 16'd456; select = 3'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("midrst_out", out, 0);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_done", done, 0);
      check_val("midrst_flags", {z_flag, n_flag, c_flag}, 0);
      @(negedge clk); rst = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         check_val("no_done_after_rst", done, 0);
      end
      run_op(16'd1, 16'd2, 3'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_alu_multicycle
